// File: rtl/mult_job_sequencer.sv
// Job sequencer wrapped around the sequential 8x8 multiplier: operand handshake, start pulse, done detect, result handshake.
// Optional WAIT-state timeout abort is enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_job_sequencer #(
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [15:0] mult_product,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_product,
    output logic        busy,
    output logic        timeout_err
);

    if (START_CYCLES < 1 || START_CYCLES > 3 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_param
        $error("mult_job_sequencer: START_CYCLES must be 1..3 and TIMEOUT_CYCLES 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESULT} state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] start_cnt;
    logic       done_q;
    logic       accept;
    logic       complete;
    logic       start_last;
    logic       timeout_hit;

`ifdef MULT_SEQ_TIMEOUT_EN
    logic [3:0] to_cnt;
`endif

    assign in_ready = (state == S_IDLE);

    // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        accept      = (state == S_IDLE) && in_valid;
        // Rising edge only: a done level left over from an earlier job is not a completion.
        complete    = (state == S_WAIT) && mult_done && !done_q;
        start_last  = (start_cnt == 2'(START_CYCLES - 1));
`ifdef MULT_SEQ_TIMEOUT_EN
        timeout_hit = (state == S_WAIT) && !complete && (to_cnt == 4'(TIMEOUT_CYCLES - 1));
`else
        timeout_hit = 1'b0;
`endif
        next_state  = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_START;
            S_START:  if (start_last) next_state = S_WAIT;
            S_WAIT:   if (complete || timeout_hit) next_state = S_RESULT;
            S_RESULT: if (res_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= S_IDLE;
            start_cnt   <= '0;
            done_q      <= 1'b0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            mult_start  <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_product <= '0;
        end else begin
            state      <= next_state;
            done_q     <= mult_done;
            // Outputs registered from next_state so they line up with the state they describe.
            mult_start <= (next_state == S_START);
            busy       <= (next_state != S_IDLE);

            if (accept) begin
                mult_dataa <= in_a;
                mult_datab <= in_b;
            end

            if (state == S_START && !start_last) start_cnt <= start_cnt + 2'd1;
            else                                 start_cnt <= '0;

            if (complete) begin
                res_product <= mult_product;
                res_valid   <= 1'b1;
            end else if (timeout_hit) begin
                res_product <= 16'h0000;
                res_valid   <= 1'b1;
            end else if (state == S_RESULT && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WAIT) to_cnt <= to_cnt + 4'd1;
            else                 to_cnt <= '0;

            if (accept)           timeout_err <= 1'b0;
            else if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed self-checking bench for mult_job_sequencer; the bench plays the multiplier (done/product).
// Define MULT_SEQ_TIMEOUT_EN for both bench and RTL to exercise the timeout abort.
module tb_mult_job_sequencer;

    localparam int START_CYCLES   = 1;
    localparam int TIMEOUT_CYCLES = 15;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [7:0]  mult_dataa;
    logic [7:0]  mult_datab;
    logic        mult_start;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_product;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mult_job_sequencer #(
        .START_CYCLES  (START_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
        .mult_start  (mult_start),
        .mult_done   (mult_done),
        .mult_product(mult_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_accept(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pass_start(input string tag);
        int n = 0;
        while (mult_start && n < 8) begin
            n++;
            tick();
        end
        check(tag, n, START_CYCLES);
    endtask

    task automatic complete_with(input logic [15:0] p);
        mult_product = p;
        mult_done    = 1'b1;
        tick();
        mult_done    = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        aclr_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", mult_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_dataa", mult_dataa, 0);

        // 1: FF x FF
        do_accept(8'hFF, 8'hFF);
        check("t1_start", mult_start, 1);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 0);
        check("t1_dataa", mult_dataa, 8'hFF);
        check("t1_datab", mult_datab, 8'hFF);
        pass_start("t1_start_len");
        repeat (3) tick();
        check("t1_wait_no_valid", res_valid, 0);
        complete_with(16'hFE01);
        check("t1_res_valid", res_valid, 1);
        check("t1_product", res_product, 16'hFE01);
        check("t1_timeout", timeout_err, 0);
        handshake();
        check("t1_valid_drop", res_valid, 0);
        check("t1_idle_ready", in_ready, 1);
        check("t1_idle_busy", busy, 0);

        // 2: result held under backpressure
        do_accept(8'h0C, 8'h0A);
        pass_start("t2_start_len");
        tick();
        complete_with(16'h0078);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", res_valid, 1);
            check("t2_hold_product", res_product, 16'h0078);
            check("t2_hold_in_ready", in_ready, 0);
            tick();
        end
        handshake();
        check("t2_idle_ready", in_ready, 1);
        check("t2_valid_drop", res_valid, 0);

        // 3: in_valid held while busy
        do_accept(8'h12, 8'h34);
        in_valid = 1'b1;
        in_a     = 8'h33;
        in_b     = 8'h44;
        pass_start("t3_start_len");
        check("t3_dataa_mid", mult_dataa, 8'h12);
        tick();
        check("t3_datab_mid", mult_datab, 8'h34);
        complete_with(16'h03A8);
        check("t3_product", res_product, 16'h03A8);
        check("t3_dataa_result", mult_dataa, 8'h12);
        handshake();
        check("t3_idle_ready", in_ready, 1);
        check("t3_dataa_idle", mult_dataa, 8'h12);
        tick();
        in_valid = 1'b0;
        check("t3_second_busy", busy, 1);
        check("t3_second_dataa", mult_dataa, 8'h33);
        check("t3_second_datab", mult_datab, 8'h44);
        pass_start("t3_second_start_len");
        complete_with(16'h0D8C);
        check("t3_second_product", res_product, 16'h0D8C);
        handshake();

        // 4: stale done level must not complete
        do_accept(8'h0D, 8'h0B);
        mult_done    = 1'b1;
        mult_product = 16'hDEAD;
        pass_start("t4_start_len");
        check("t4_stale_done_a", res_valid, 0);
        tick();
        check("t4_stale_done_b", res_valid, 0);
        mult_done = 1'b0;
        tick();
        check("t4_done_low", res_valid, 0);
        complete_with(16'h008F);
        check("t4_valid", res_valid, 1);
        check("t4_product", res_product, 16'h008F);
        handshake();

        // 5: reset mid-WAIT
        do_accept(8'h05, 8'h07);
        pass_start("t5_start_len");
        tick();
        mult_done    = 1'b1;
        mult_product = 16'h0023;
        aclr_n       = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_start", mult_start, 0);
        check("t5_rst_valid", res_valid, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_dataa", mult_dataa, 0);
        check("t5_rst_product", res_product, 0);
        @(negedge clk);
        aclr_n = 1'b1;
        tick();
        check("t5_post_valid", res_valid, 0);
        check("t5_post_busy", busy, 0);
        check("t5_post_start", mult_start, 0);
        mult_done = 1'b0;
        tick();
        do_accept(8'h05, 8'h07);
        pass_start("t5_job_start_len");
        tick();
        complete_with(16'h0023);
        check("t5_job_product", res_product, 16'h0023);
        check("t5_job_valid", res_valid, 1);
        handshake();

`ifdef MULT_SEQ_TIMEOUT_EN
        // 6: timeout abort
        begin
            int n = 0;
            mult_product = 16'hBEEF;
            do_accept(8'h02, 8'h03);
            pass_start("t6_start_len");
            while (!res_valid && n < 40) begin
                tick();
                n++;
            end
            check("t6_wait_cycles", n, TIMEOUT_CYCLES);
            check("t6_product", res_product, 16'h0000);
            check("t6_timeout", timeout_err, 1);
            handshake();
            check("t6_timeout_sticky", timeout_err, 1);
            do_accept(8'h01, 8'h01);
            check("t6_timeout_clear", timeout_err, 0);
            pass_start("t6_next_start_len");
            complete_with(16'h0001);
            check("t6_next_product", res_product, 16'h0001);
            handshake();
        end
`else
        // 6: without timeout logic WAIT persists indefinitely
        do_accept(8'h02, 8'h03);
        pass_start("t6_start_len");
        repeat (20) tick();
        check("t6_long_wait_valid", res_valid, 0);
        check("t6_long_wait_busy", busy, 1);
        check("t6_timeout_tied", timeout_err, 0);
        complete_with(16'h0006);
        check("t6_product", res_product, 16'h0006);
        handshake();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
